sh4a_fetch: RTL and testbench

- Instruction fetch stage directly upstream of sh4a_decode.
- Issues 32-bit aligned reads to instruction memory and splits each returned word into two 16-bit SH-4 instructions (little-endian).
- Buffers the instructions in a small halfword queue and presents one instruction per cycle, with its PC, over a valid/ready handshake.
- Handles branch redirects: flushes the queue, drops any in-flight response and restarts at any halfword-aligned PC.

---
 rtl/sh4a_fetch_pkg.sv | 21 ++
 rtl/sh4a_fetch_queue.sv | 47 ++++
 rtl/sh4a_fetch.sv | 97 +++++++++
 tb/tb_sh4a_fetch.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/sh4a_fetch_pkg.sv
// sh4a_fetch_pkg: shared constants, queue entry type and alignment helpers for the fetch stage.
package sh4a_fetch_pkg;
  localparam logic [31:0] SH4A_RESET_PC   = 32'hA000_0000;
  localparam logic [15:0] SH4A_NOP_INSN   = 16'h0009;
  localparam int          SH4A_INSN_BYTES = 2;

  typedef enum logic [0:0] {ST_BOOT, ST_FETCH} fetch_state_e;

  typedef struct packed {
    logic [15:0] insn;
    logic [31:0] pc;
  } qent_t;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return a & ~32'd3;
  endfunction

  function automatic logic [31:0] half_align(input logic [31:0] a);
    return a & ~32'd1;
  endfunction
endpackage

// File: rtl/sh4a_fetch_queue.sv
// sh4a_fetch_queue: halfword FIFO with a two-entry push port (lo then hi), single pop and sync flush.
module sh4a_fetch_queue
  import sh4a_fetch_pkg::*;
#(
  parameter int QDEPTH = 8,
  localparam int AW = $clog2(QDEPTH)
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_flush,
  input  logic        i_push_lo,
  input  logic        i_push_hi,
  input  qent_t       i_lo,
  input  qent_t       i_hi,
  input  logic        i_pop,
  output qent_t       o_head,
  output logic [AW:0] o_count,
  output logic [AW:0] o_free
);
  qent_t       r_mem [QDEPTH];
  logic [AW:0] r_wr, r_rd;
  logic [AW:0] w_hi_ptr, w_n_push;
  assign w_n_push = (AW+1)'(i_push_lo) + (AW+1)'(i_push_hi);
  assign w_hi_ptr = r_wr + (AW+1)'(i_push_lo);
  assign o_count  = r_wr - r_rd;
  assign o_free   = (AW+1)'(QDEPTH) - o_count;
  assign o_head   = r_mem[r_rd[AW-1:0]];

  // Pointers carry one extra bit so a full queue is distinguishable from an empty one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr <= '0;
      r_rd <= '0;
    end else if (i_flush) begin
      r_wr <= '0;
      r_rd <= '0;
    end else begin
      r_wr <= r_wr + w_n_push;
      if (i_pop && o_count != '0) r_rd <= r_rd + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!i_flush && i_push_lo) r_mem[r_wr[AW-1:0]] <= i_lo;
    if (!i_flush && i_push_hi) r_mem[w_hi_ptr[AW-1:0]] <= i_hi;
  end
endmodule

// File: rtl/sh4a_fetch.sv
// sh4a_fetch: issues aligned word reads, splits responses into halfword instructions and
// handles branch redirects by flushing the queue and dropping stale in-flight responses.
module sh4a_fetch
  import sh4a_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = SH4A_RESET_PC,
  parameter int          QDEPTH   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        insn_valid,
  input  logic        insn_ready,
  output logic [15:0] insn,
  output logic [31:0] insn_pc
);
  localparam int AW = $clog2(QDEPTH);

  fetch_state_e r_state, w_state_n;
  logic [31:0]  r_fetch_addr, w_fetch_n;
  logic [31:0]  r_push_pc, w_pc_n;
  logic [AW-1:0] r_out, w_out_n, r_drop, w_drop_n, w_out_p1;
  logic         r_skip_lo, w_skip_n;
  logic [AW:0]  w_count, w_free, w_need;
  logic         w_empty, w_req_fire, w_resp_live, w_push_lo, w_push_hi, w_pop;
  qent_t        w_head, w_lo, w_hi;

  assign w_empty     = w_count == '0;
  assign w_out_p1    = r_out + AW'(1);
  assign w_need      = {w_out_p1, 1'b0};
  assign w_req_fire  = imem_req_valid && imem_req_ready;
  assign w_resp_live = imem_resp_valid && !redirect_valid && r_drop == '0;
  assign w_push_lo   = w_resp_live && !r_skip_lo;
  assign w_push_hi   = w_resp_live;
  assign w_pop       = insn_ready && !w_empty && !redirect_valid;
  assign w_lo        = '{insn: imem_resp_data[15:0], pc: r_push_pc};
  assign w_hi        = '{insn: imem_resp_data[31:16],
                         pc: w_push_lo ? r_push_pc + 32'(SH4A_INSN_BYTES) : r_push_pc};

  assign imem_req_addr = r_fetch_addr;
  assign insn_valid    = !w_empty;
  assign insn          = w_empty ? SH4A_NOP_INSN : w_head.insn;
  assign insn_pc       = w_empty ? r_push_pc : w_head.pc;

  sh4a_fetch_queue #(.QDEPTH(QDEPTH)) u_queue (
    .clk       (clk),
    .rst       (rst),
    .i_flush   (redirect_valid),
    .i_push_lo (w_push_lo),
    .i_push_hi (w_push_hi),
    .i_lo      (w_lo),
    .i_hi      (w_hi),
    .i_pop     (w_pop),
    .o_head    (w_head),
    .o_count   (w_count),
    .o_free    (w_free)
  );

  // A request is only issued when every outstanding response, plus this one, can land in the queue.
  always_comb begin
    w_state_n      = ST_FETCH;
    imem_req_valid = r_state == ST_FETCH && !redirect_valid && w_free >= w_need;
    w_fetch_n      = redirect_valid ? word_align(redirect_pc)
                                    : r_fetch_addr + (w_req_fire ? 32'd4 : 32'd0);
    w_pc_n         = redirect_valid ? half_align(redirect_pc)
                   : r_push_pc + (w_push_lo ? 32'(2 * SH4A_INSN_BYTES)
                                : w_push_hi ? 32'(SH4A_INSN_BYTES) : 32'd0);
    w_out_n        = r_out + AW'(w_req_fire) - AW'(imem_resp_valid);
    w_drop_n       = redirect_valid ? r_out - AW'(imem_resp_valid)
                                    : r_drop - AW'(imem_resp_valid && r_drop != '0);
    w_skip_n       = redirect_valid ? redirect_pc[1] : (w_resp_live ? 1'b0 : r_skip_lo);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= ST_BOOT;
      r_fetch_addr <= word_align(RESET_PC);
      r_push_pc    <= half_align(RESET_PC);
      r_out        <= '0;
      r_drop       <= '0;
      r_skip_lo    <= RESET_PC[1];
    end else begin
      r_state      <= w_state_n;
      r_fetch_addr <= w_fetch_n;
      r_push_pc    <= w_pc_n;
      r_out        <= w_out_n;
      r_drop       <= w_drop_n;
      r_skip_lo    <= w_skip_n;
    end
  end
endmodule

// File: tb/tb_sh4a_fetch.sv
// tb_sh4a_fetch: directed stimulus with an address-indexed instruction memory model;
// every presented instruction must be the memory halfword at the next expected PC.
module tb_sh4a_fetch;
  localparam int QD = 8;

  logic        clk = 0, rst = 1;
  logic        redirect_valid = 0, imem_req_ready = 1, imem_resp_valid = 0, insn_ready = 1;
  logic [31:0] redirect_pc = 0, imem_resp_data = 0;
  logic        imem_req_valid, insn_valid;
  logic [31:0] imem_req_addr, insn_pc;
  logic [15:0] insn;

  int n_chk = 0, n_err = 0;
  int lat = 1, mem_out = 0, n_acc = 0, cyc = 0;
  logic [31:0] acc_log[$], cons_log[$];
  typedef struct {logic [31:0] addr; int due;} mreq_t;
  mreq_t mq[$];
  logic [31:0] exp_pc = 32'hA000_0000;
  bit redir_prev = 0;

  always #5 clk = ~clk;

  sh4a_fetch #(.RESET_PC(32'hA000_0000), .QDEPTH(QD)) dut (
    .clk(clk), .rst(rst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .insn_valid(insn_valid), .insn_ready(insn_ready), .insn(insn), .insn_pc(insn_pc)
  );

  function automatic logic [15:0] hw_at(input logic [31:0] a);
    logic [31:0] w = a & ~32'd3;
    logic [31:0] h = a & ~32'd1;
    if (w == 32'hA000_0000) return a[1] ? 16'h6123 : 16'h0009;
    if (w == 32'h8C00_0100) return a[1] ? 16'hAAAA : 16'hBBBB;
    return h[15:0] ^ h[31:16] ^ 16'h3C5A;
  endfunction

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {hw_at(a + 32'd2), hw_at(a)};
  endfunction

  function automatic logic [31:0] qat(input logic [31:0] q[$], input int i);
    return (i < q.size()) ? q[i] : 32'hDEAD_BEEF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic redirect(input logic [31:0] pc);
    redirect_pc = pc;
    redirect_valid = 1;
    step();
    redirect_valid = 0;
  endtask

  task automatic wait_head(input string name, input logic [31:0] pc, input logic [15:0] ins);
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (insn_valid) break;
    end
    chk({name, "_valid"}, insn_valid, 1);
    chk({name, "_pc"}, insn_pc, pc);
    chk({name, "_insn"}, insn, ins);
  endtask

  // In-order memory with configurable latency; requests sampled mid-cycle.
  initial forever begin
    @(negedge clk);
    if (rst) begin
      mq.delete();
      mem_out = 0;
    end else begin
      if (imem_req_valid && imem_req_ready) begin
        mq.push_back('{imem_req_addr, cyc + lat});
        acc_log.push_back(imem_req_addr);
        mem_out++;
        n_acc++;
      end
      if (imem_resp_valid) mem_out--;
      chk("outstanding_bound", mem_out <= QD / 2, 1);
    end
    @(posedge clk);
    #1;
    cyc++;
    if (!rst && mq.size() > 0 && mq[0].due <= cyc) begin
      imem_resp_valid = 1;
      imem_resp_data = mem_word(mq[0].addr);
      void'(mq.pop_front());
    end else imem_resp_valid = 0;
  end

  // Stream model: the head is always the memory halfword at the next expected PC.
  initial forever begin
    @(negedge clk);
    if (rst) begin
      exp_pc = 32'hA000_0000;
      redir_prev = 0;
    end else begin
      if (redir_prev) chk("valid_after_redirect", insn_valid, 0);
      if (insn_valid) begin
        chk("stream_pc", insn_pc, exp_pc);
        chk("stream_insn", insn, hw_at(exp_pc));
      end else chk("empty_nop", insn, 16'h0009);
      if (redirect_valid) exp_pc = redirect_pc & ~32'd1;
      else if (insn_valid && insn_ready) begin
        cons_log.push_back(insn_pc);
        exp_pc = exp_pc + 32'd2;
      end
      redir_prev = redirect_valid;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1);
  end

  initial begin
    int n0;
    rst = 1;
    step(3);
    @(negedge clk);
    chk("rst_req_valid", imem_req_valid, 0);
    chk("rst_req_addr", imem_req_addr, 32'hA000_0000);
    chk("rst_insn_valid", insn_valid, 0);
    chk("rst_insn", insn, 16'h0009);
    chk("rst_insn_pc", insn_pc, 32'hA000_0000);
    step();
    rst = 0;
    @(negedge clk);
    chk("boot_idle_req", imem_req_valid, 0);
    step();
    @(negedge clk);
    chk("boot_req_valid", imem_req_valid, 1);
    chk("boot_req_addr", imem_req_addr, 32'hA000_0000);
    wait_head("boot0", 32'hA000_0000, 16'h0009);
    @(negedge clk);
    chk("boot1_pc", insn_pc, 32'hA000_0002);
    chk("boot1_insn", insn, 16'h6123);

    step();
    insn_ready = 0;
    n0 = n_acc;
    redirect(32'h8C00_1000);
    step(20);
    chk("bp_accepted", n_acc - n0, 4);
    @(negedge clk);
    chk("bp_req_stalled", imem_req_valid, 0);
    chk("bp_head_pc", insn_pc, 32'h8C00_1000);
    step();
    cons_log.delete();
    insn_ready = 1;
    step(12);
    for (int i = 0; i < 8; i++) chk("bp_order", qat(cons_log, i), 32'h8C00_1000 + 32'(2 * i));

    redirect(32'h8C00_0102);
    @(negedge clk);
    chk("unal_req_valid", imem_req_valid, 1);
    chk("unal_req_addr", imem_req_addr, 32'h8C00_0100);
    wait_head("unal", 32'h8C00_0102, 16'hAAAA);

    lat = 5;
    step();
    redirect(32'h8C00_1800);
    for (int i = 0; i < 40; i++) begin
      if (mem_out == 3) break;
      step();
    end
    chk("inflight_setup", mem_out, 3);
    redirect(32'h8C00_0200);
    wait_head("inflight", 32'h8C00_0200, 16'hB25A);

    lat = 1;
    step(10);
    for (int i = 0; i < 40; i++) begin
      step();
      #1;
      if (imem_resp_valid && insn_valid) break;
    end
    chk("simul_setup", imem_resp_valid && insn_valid, 1);
    redirect(32'h8C00_0300);
    @(negedge clk);
    chk("simul_empty", insn_valid, 0);
    wait_head("simul", 32'h8C00_0300, 16'hB35A);

    step();
    acc_log.delete();
    cons_log.delete();
    redirect(32'hFFFF_FFFC);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (acc_log.size() >= 2 && cons_log.size() >= 3) break;
    end
    chk("wrap_req0", qat(acc_log, 0), 32'hFFFF_FFFC);
    chk("wrap_req1", qat(acc_log, 1), 32'h0000_0000);
    chk("wrap_pc0", qat(cons_log, 0), 32'hFFFF_FFFC);
    chk("wrap_pc1", qat(cons_log, 1), 32'hFFFF_FFFE);
    chk("wrap_pc2", qat(cons_log, 2), 32'h0000_0000);

    step(3);
    rst = 1;
    #1;
    chk("midrst_insn_valid", insn_valid, 0);
    chk("midrst_req_valid", imem_req_valid, 0);
    chk("midrst_req_addr", imem_req_addr, 32'hA000_0000);
    step(2);
    rst = 0;
    wait_head("midrst", 32'hA000_0000, 16'h0009);

    step(5);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
